// File: rtl/uart_fink_transmitter_pkg.sv
// uart_fink_transmitter_pkg
//   Shared definitions for the Fink-coded UART link (transmitter and receiver).
//   Holds default link parameters, the FSM state encoding and size helpers.
package uart_fink_transmitter_pkg;

    localparam int unsigned MSG_SIZE_DEF   = 6;
    localparam int unsigned STEP_DEF       = 0;
    localparam int unsigned BIT_CYCLES_DEF = 3000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Code delay D for a given interleave step.
    function automatic int unsigned code_delay(input int unsigned step);
        return 2 * step + 1;
    endfunction

    // Rate-1/2 coded length including the 2D-bit zero flush.
    function automatic int unsigned coded_size(input int unsigned msg_size,
                                               input int unsigned step);
        return 2 * (msg_size + 2 * code_delay(step));
    endfunction

    // Counter width that stays at least one bit wide when n == 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_fink_transmitter_encoder.sv
// uart_fink_transmitter_encoder
//   Purely combinational Fink convolutional encoder (rate 1/2).
//   Ports:
//     message  in   MSG_SIZE        payload
//     coded    out  CODED_MSG_SIZE  interleaved info/check bits, coded[0] sent first
module uart_fink_transmitter_encoder
    import uart_fink_transmitter_pkg::*;
#(
    parameter int unsigned MSG_SIZE = MSG_SIZE_DEF,
    parameter int unsigned STEP     = STEP_DEF
) (
    input  logic [MSG_SIZE-1:0]                      message,
    output logic [coded_size(MSG_SIZE, STEP)-1:0]    coded
);

    localparam int unsigned D = code_delay(STEP);
    localparam int unsigned N = MSG_SIZE + 2 * D;

    // 2D zeros below stand in for d[negative], 2D zeros above are the flush.
    // With this padding d[i] = d_pad[i+2D], d[i-D] = d_pad[i+D], d[i-2D] = d_pad[i].
    logic [MSG_SIZE+4*D-1:0] d_pad;

    assign d_pad = {{(2*D){1'b0}}, message, {(2*D){1'b0}}};

    always_comb begin
        coded = '0;
        for (int i = 0; i < int'(N); i++) begin
            coded[2*i]   = d_pad[i+2*D];
            coded[2*i+1] = d_pad[i+D] ^ d_pad[i];
        end
    end

endmodule

// File: rtl/uart_fink_transmitter.sv
// uart_fink_transmitter
//   Transmit end of the Fink-coded UART link. Latches and encodes a message on
//   start, then sends start bit, coded bits LSB-first, stop bit on tx.
//   Ports:
//     clk      in   1         system clock
//     rst_n    in   1         asynchronous active-low reset
//     start    in   1         one-cycle request, honoured only while busy=0
//     message  in   MSG_SIZE  payload, captured when start is accepted
//     tx       out  1         serial line, idle high (registered)
//     busy     out  1         frame in progress
//     done     out  1         one-cycle pulse after the stop bit
//
//   state    | meaning
//   ST_IDLE  | line high, waiting for start (also the done-pulse cycle)
//   ST_START | start bit (tx=0) for BIT_CYCLES
//   ST_DATA  | coded bits, one per BIT_CYCLES
//   ST_STOP  | stop bit (tx=1) for BIT_CYCLES
module uart_fink_transmitter
    import uart_fink_transmitter_pkg::*;
#(
    parameter int unsigned MSG_SIZE   = MSG_SIZE_DEF,
    parameter int unsigned STEP       = STEP_DEF,
    parameter int unsigned BIT_CYCLES = BIT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [MSG_SIZE-1:0] message,
    output logic                tx,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CODED = coded_size(MSG_SIZE, STEP);
    localparam int unsigned CW    = cnt_width(BIT_CYCLES);
    localparam int unsigned IW    = $clog2(CODED + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(CODED - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CODED-1:0]  shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CODED-1:0]  coded_w;
    logic              cnt_last;

    uart_fink_transmitter_encoder #(
        .MSG_SIZE (MSG_SIZE),
        .STEP     (STEP)
    ) u_encoder (
        .message (message),
        .coded   (coded_w)
    );

    assign cnt_last = (cnt_q == CNT_LAST);

    // Outputs are computed one cycle early so every line transition is a flop edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    shift_d = coded_w;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
